// File: rtl/gpr_writeback.sv
// gpr_writeback: write-back sequencer for the multi-cycle MIPS core.
// Accepts one completed instruction descriptor over wb_valid/wb_ready. For
// loads it waits for mem_rvalid, then extracts and extends the loaded value.
// It then drives one registered write-port cycle into the register file.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   wb_valid / wb_ready     descriptor handshake (ready only while idle)
//   wb_src, wb_dst          source select (0 ALU, 1 MEM, 2 LINK, 3 none), dest reg
//   wb_ovf_chk, alu_ovf     overflow trap enable and ALU signed-overflow flag
//   alu_result, pc_plus4    ALU result (low bits = load byte offset), link value
//   ld_size, ld_unsigned    load width (0 byte, 1 half, 2 word) and extension mode
//   mem_rvalid, mem_rdata   memory read data (big-endian lanes)
//   RegWrite, overflow,
//   write_reg, write_data   register-file write port (registered)
//   wb_done, wb_err         retire pulse; error pulse on memory timeout
module gpr_writeback #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [1:0]  wb_src,
  input  logic [4:0]  wb_dst,
  input  logic        wb_ovf_chk,
  input  logic [31:0] alu_result,
  input  logic        alu_ovf,
  input  logic [31:0] pc_plus4,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        RegWrite,
  output logic        overflow,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        wb_done,
  output logic        wb_err
);

  typedef enum logic [1:0] {StIdle, StWaitMem, StWrite} state_e;

  // Abort fires on the edge where the counter has already spent MEM_TIMEOUT-1 cycles.
  localparam logic [7:0] CntLimit = 8'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  dst_q, dst_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic        regwrite_q, regwrite_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [4:0]  wreg_q, wreg_d;
  logic [31:0] wdata_q, wdata_d;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_val;

  // Load extraction; lane 0 is the most significant byte.
  always_comb begin
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    ld_val   = mem_rdata;
    case (off_q)
      2'd0:    byte_sel = mem_rdata[31:24];
      2'd1:    byte_sel = mem_rdata[23:16];
      2'd2:    byte_sel = mem_rdata[15:8];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    case (size_q)
      2'd0:    ld_val = {{24{byte_sel[7] & ~uns_q}}, byte_sel};
      2'd1:    ld_val = {{16{half_sel[15] & ~uns_q}}, half_sel};
      default: ld_val = mem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dst_d      = dst_q;
    size_d     = size_q;
    uns_d      = uns_q;
    off_d      = off_q;
    regwrite_d = 1'b0;
    ovf_d      = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    case (state_q)
      StIdle: begin
        if (wb_valid) begin
          dst_d  = wb_dst;
          size_d = ld_size;
          uns_d  = ld_unsigned;
          off_d  = alu_result[1:0];
          if (wb_src == 2'd1) begin
            state_d = StWaitMem;
            cnt_d   = 8'd0;
          end else begin
            // Non-load results are known now, so the write-port flops load on accept.
            state_d    = StWrite;
            ovf_d      = (wb_src == 2'd0) & wb_ovf_chk & alu_ovf;
            regwrite_d = ovf_d | ((wb_src != 2'd3) && (wb_dst != 5'd0));
            done_d     = 1'b1;
            wreg_d     = wb_dst;
            if (wb_src == 2'd0) wdata_d = alu_result;
            else if (wb_src == 2'd2) wdata_d = pc_plus4;
          end
        end
      end
      StWaitMem: begin
        if (mem_rvalid) begin
          state_d    = StWrite;
          regwrite_d = (dst_q != 5'd0);
          done_d     = 1'b1;
          wreg_d     = dst_q;
          wdata_d    = ld_val;
        end else if (cnt_q == CntLimit) begin
          state_d = StIdle;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      dst_q      <= 5'd0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      off_q      <= 2'd0;
      regwrite_q <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wreg_q     <= 5'd0;
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dst_q      <= dst_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      off_q      <= off_d;
      regwrite_q <= regwrite_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
    end
  end

  assign wb_ready   = (state_q == StIdle);
  assign RegWrite   = regwrite_q;
  assign overflow   = ovf_q;
  assign wb_done    = done_q;
  assign wb_err     = err_q;
  assign write_reg  = wreg_q;
  assign write_data = wdata_q;

endmodule

// File: tb/tb_gpr_writeback.sv
module tb_gpr_writeback;

  localparam int T = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [1:0]  wb_src = 2'd0;
  logic [4:0]  wb_dst = 5'd0;
  logic        wb_ovf_chk = 1'b0;
  logic [31:0] alu_result = 32'd0;
  logic        alu_ovf = 1'b0;
  logic [31:0] pc_plus4 = 32'd0;
  logic [1:0]  ld_size = 2'd0;
  logic        ld_unsigned = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        RegWrite, overflow, wb_done, wb_err;
  logic [4:0]  write_reg;
  logic [31:0] write_data;

  gpr_writeback #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_src(wb_src), .wb_dst(wb_dst), .wb_ovf_chk(wb_ovf_chk), .alu_result(alu_result),
    .alu_ovf(alu_ovf), .pc_plus4(pc_plus4), .ld_size(ld_size), .ld_unsigned(ld_unsigned),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .RegWrite(RegWrite),
    .overflow(overflow), .write_reg(write_reg), .write_data(write_data),
    .wb_done(wb_done), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at_cyc;
    logic        rw;
    logic        ovf;
    logic        err;
    logic        upd_reg;
    logic        upd_data;
    logic [4:0]  reg_n;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference load: pick the big-endian lane by shifting, then mask and extend.
  function automatic logic [31:0] ld_model(input logic [31:0] word, input logic [1:0] off,
                                           input logic [1:0] sz, input logic uns);
    int bits;
    int sh;
    logic [31:0] mask;
    logic [31:0] v;
    if (sz == 2'd0) begin
      bits = 8;
      sh = 8 * (3 - int'(off));
    end else if (sz == 2'd1) begin
      bits = 16;
      sh = off[1] ? 0 : 16;
    end else begin
      bits = 32;
      sh = 0;
    end
    v = word >> sh;
    if (bits < 32) begin
      mask = (32'd1 << bits) - 32'd1;
      v = v & mask;
      if (!uns && v[bits-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // Monitor: write-port outputs checked every cycle against the scoreboard.
  logic [4:0]  m_reg = 5'd0;
  logic [31:0] m_data = 32'd0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      m_reg = 5'd0;
      m_data = 32'd0;
    end else begin
      if (wb_done) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got wb_done=1 expected no retire (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.at_cyc);
          chk("RegWrite", {31'd0, RegWrite}, {31'd0, e.rw});
          chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
          chk("wb_err", {31'd0, wb_err}, {31'd0, e.err});
          if (e.upd_reg) m_reg = e.reg_n;
          if (e.upd_data) m_data = e.data;
        end
      end else begin
        chk("idle_RegWrite", {31'd0, RegWrite}, 32'd0);
        chk("idle_overflow", {31'd0, overflow}, 32'd0);
        chk("idle_wb_err", {31'd0, wb_err}, 32'd0);
      end
      chk("write_reg", {27'd0, write_reg}, {27'd0, m_reg});
      chk("write_data", write_data, m_data);
    end
  end

  task automatic issue(input logic [1:0] src, input logic [4:0] dst, input logic oc,
                       input logic ao, input logic [31:0] alu, input logic [31:0] pc,
                       input logic [1:0] sz, input logic uns, input int dly,
                       input logic [31:0] rdata, input bit rst_mid);
    exp_t e;
    int w;
    int c;
    w = 0;
    while (!wb_ready && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("ready_idle", {31'd0, wb_ready}, 32'd1);
    wb_valid = 1'b1;
    wb_src = src;
    wb_dst = dst;
    wb_ovf_chk = oc;
    alu_ovf = ao;
    alu_result = alu;
    pc_plus4 = pc;
    ld_size = sz;
    ld_unsigned = uns;
    @(posedge clk);
    #1;
    c = cyc;
    wb_valid = 1'b0;
    wb_src = 2'($urandom);
    wb_dst = 5'($urandom);
    wb_ovf_chk = 1'($urandom);
    alu_ovf = 1'($urandom);
    alu_result = $urandom;
    pc_plus4 = $urandom;
    ld_size = 2'($urandom);
    ld_unsigned = 1'($urandom);
    chk("ready_busy", {31'd0, wb_ready}, 32'd0);

    e.ovf = (src == 2'd0) && oc && ao;
    e.rw = e.ovf || (src != 2'd3 && dst != 5'd0);
    e.err = 1'b0;
    e.upd_reg = 1'b1;
    e.upd_data = (src != 2'd3);
    e.reg_n = dst;
    e.at_cyc = c;
    e.data = (src == 2'd0) ? alu : (src == 2'd2) ? pc : ld_model(rdata, alu[1:0], sz, uns);
    if (src == 2'd1) begin
      if (dly <= T) begin
        e.at_cyc = c + dly;
      end else begin
        e.at_cyc = c + T;
        e.err = 1'b1;
        e.rw = 1'b0;
        e.ovf = 1'b0;
        e.upd_reg = 1'b0;
        e.upd_data = 1'b0;
      end
    end
    if (!rst_mid) sb.push_back(e);

    if (src == 2'd1) begin
      if (rst_mid) begin
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        reset = 1'b1;
        repeat (2) begin
          @(posedge clk);
          #1;
        end
        chk("rst_RegWrite", {31'd0, RegWrite}, 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", {31'd0, wb_ready}, 32'd1);
      end else begin
        for (int i = 1; i <= dly; i++) begin
          if (i == dly && dly <= T) begin
            mem_rvalid = 1'b1;
            mem_rdata = rdata;
          end else begin
            mem_rvalid = 1'b0;
            mem_rdata = $urandom;
          end
          @(posedge clk);
          #1;
        end
        mem_rvalid = 1'b0;
        mem_rdata = $urandom;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected $finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_ready", {31'd0, wb_ready}, 32'd1);
    chk("reset_write_reg", {27'd0, write_reg}, 32'd0);
    chk("reset_write_data", write_data, 32'd0);

    // Directed cases
    issue(2'd0, 5'd5, 1'b0, 1'b0, 32'h0000_1234, 32'd0, 2'd0, 1'b0, 0, 32'd0, 1'b0);
    issue(2'd0, 5'd8, 1'b1, 1'b1, 32'h8000_0000, 32'd0, 2'd0, 1'b0, 0, 32'd0, 1'b0);
    issue(2'd0, 5'd8, 1'b0, 1'b1, 32'h8000_0000, 32'd0, 2'd0, 1'b0, 0, 32'd0, 1'b0);
    issue(2'd1, 5'd9, 1'b0, 1'b0, 32'h0000_1001, 32'd0, 2'd0, 1'b0, 3, 32'h12F0_5678, 1'b0);
    issue(2'd1, 5'd9, 1'b0, 1'b0, 32'h0000_1001, 32'd0, 2'd0, 1'b1, 3, 32'h12F0_5678, 1'b0);
    issue(2'd1, 5'd10, 1'b0, 1'b0, 32'h0000_1002, 32'd0, 2'd1, 1'b1, 3, 32'h12F0_5678, 1'b0);
    issue(2'd0, 5'd0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'd0, 2'd0, 1'b0, 0, 32'd0, 1'b0);
    issue(2'd3, 5'd7, 1'b0, 1'b0, 32'hCAFE_0000, 32'd0, 2'd0, 1'b0, 0, 32'd0, 1'b0);
    issue(2'd2, 5'd31, 1'b0, 1'b0, 32'd0, 32'h0040_0104, 2'd0, 1'b0, 0, 32'd0, 1'b0);
    issue(2'd1, 5'd11, 1'b0, 1'b0, 32'h0000_2000, 32'd0, 2'd2, 1'b0, T + 3, 32'd0, 1'b0);
    issue(2'd1, 5'd12, 1'b0, 1'b0, 32'h0000_2000, 32'd0, 2'd2, 1'b0, T, 32'hA5A5_5A5A, 1'b0);
    issue(2'd1, 5'd13, 1'b0, 1'b0, 32'h0000_2000, 32'd0, 2'd2, 1'b0, 5, 32'd0, 1'b1);
    issue(2'd0, 5'd14, 1'b0, 1'b0, 32'h0BAD_F00D, 32'd0, 2'd0, 1'b0, 0, 32'd0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      logic [1:0] src;
      int dly;
      src = 2'($urandom);
      dly = ($urandom_range(0, 9) == 0) ? int'($urandom_range(T - 1, T + 2))
                                        : int'($urandom_range(1, 6));
      issue(src, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), 1'($urandom),
            1'($urandom), $urandom, $urandom, 2'($urandom_range(0, 2)), 1'($urandom),
            dly, $urandom, 1'b0);
    end

    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("scoreboard_drained", sb.size(), 32'd0);
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
